// File: rtl/cp0_unit.sv
// MIPS coprocessor-0 at the memory stage: SR/Cause/EPC/PRId, interrupt and
// exception arbitration, mfc0/mtc0 access and eret EXL clear.
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h0000_7001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  sr_im_r;
  logic        sr_exl_r;
  logic        sr_ie_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  cause_exc_r;
  logic [31:0] epc_r;

  logic [5:0]  sr_im_n;
  logic        sr_exl_n;
  logic        sr_ie_n;
  logic        cause_bd_n;
  logic [4:0]  cause_exc_n;
  logic [31:0] epc_n;

  logic        int_req;
  logic        exc_req;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] epc_fault;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Request arbitration; EXL masks everything so handlers cannot nest.
  always_comb begin
    int_req = (|(HWInt & sr_im_r)) & sr_ie_r & ~sr_exl_r;
    exc_req = (ExcCode != 5'd0) & ~sr_exl_r;
    Req     = int_req | exc_req;
    sr_wr   = WE & (A2 == REG_SR);
    epc_wr  = WE & (A2 == REG_EPC);
  end

  // Delay-slot instructions restart at the branch; PC-4 wraps modulo 2^32.
  always_comb begin
    if (BD) begin
      epc_fault = PC - 32'd4;
    end else begin
      epc_fault = PC;
    end
    epc_fault[1:0] = 2'b00;
  end

  // Next-state for SR/Cause/EPC; a taken request overrides any mtc0 or eret.
  always_comb begin
    sr_im_n     = sr_im_r;
    sr_exl_n    = sr_exl_r;
    sr_ie_n     = sr_ie_r;
    cause_bd_n  = cause_bd_r;
    cause_exc_n = cause_exc_r;
    epc_n       = epc_r;
    if (Req) begin
      sr_exl_n   = 1'b1;
      cause_bd_n = BD;
      if (int_req) begin
        cause_exc_n = 5'd0;
      end else begin
        cause_exc_n = ExcCode;
      end
      epc_n = epc_fault;
    end else begin
      if (sr_wr) begin
        sr_im_n = DIn[15:10];
        sr_ie_n = DIn[0];
      end else begin
        sr_im_n = sr_im_r;
        sr_ie_n = sr_ie_r;
      end
      // eret beats a same-cycle mtc0 for the EXL bit only
      if (EXLClr) begin
        sr_exl_n = 1'b0;
      end else if (sr_wr) begin
        sr_exl_n = DIn[1];
      end else begin
        sr_exl_n = sr_exl_r;
      end
      if (epc_wr) begin
        epc_n = DIn;
      end else begin
        epc_n = epc_r;
      end
    end
  end

  // State registers; Cause.IP samples the interrupt lines every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im_r     <= 6'd0;
      sr_exl_r    <= 1'b0;
      sr_ie_r     <= 1'b0;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= 32'd0;
    end else begin
      sr_im_r     <= sr_im_n;
      sr_exl_r    <= sr_exl_n;
      sr_ie_r     <= sr_ie_n;
      cause_bd_r  <= cause_bd_n;
      cause_ip_r  <= HWInt;
      cause_exc_r <= cause_exc_n;
      epc_r       <= epc_n;
    end
  end

  // Architectural register views and the mfc0 read mux.
  always_comb begin
    sr_word    = {16'd0, sr_im_r, 8'd0, sr_exl_r, sr_ie_r};
    cause_word = {cause_bd_r, 15'd0, cause_ip_r, 3'd0, cause_exc_r, 2'd0};
    EPCOut     = epc_r;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_r;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic
// compared against a word-level reference model of the CP0 registers.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_7001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  A1 = 5'd0;
  logic [4:0]  A2 = 5'd0;
  logic [31:0] DIn = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] PC = 32'd0;
  logic        BD = 1'b0;
  logic [4:0]  ExcCode = 5'd0;
  logic [5:0]  HWInt = 6'd0;
  logic        EXLClr = 1'b0;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state, as whole architectural words
  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;

  cp0_unit #(.PRID_VAL(PRID)) dut (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
    .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #10 clk = ~clk;

  function automatic logic m_int();
    return (|(HWInt & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() | ((ExcCode != 5'd0) & ~m_sr[1]);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock, applying the architectural rules to the model.
  task automatic clock_step();
    logic [31:0] nsr, ncause, nepc;
    nsr    = m_sr;
    nepc   = m_epc;
    ncause = (m_cause & 32'h8000_007C) | (32'(HWInt) << 10);
    if (m_req()) begin
      nsr    = m_sr | 32'h2;
      ncause = (ncause & 32'h0000_FC00) | (32'(BD) << 31)
             | (m_int() ? 32'd0 : (32'(ExcCode) << 2));
      nepc   = (BD ? (PC - 32'd4) : PC) & 32'hFFFF_FFFC;
    end else begin
      if (WE && A2 == 5'd12) nsr = DIn & 32'h0000_FC03;
      if (EXLClr) nsr = nsr & ~32'h2;
      if (WE && A2 == 5'd14) nepc = DIn;
    end
    @(posedge clk);
    if (rst_n) begin
      m_sr = nsr;
      m_cause = ncause;
      m_epc = nepc;
    end
    #1;
  endtask

  task automatic set_inputs(input logic [4:0] a2, input logic [31:0] din,
                            input logic we, input logic [31:0] pc, input logic bd,
                            input logic [4:0] ec, input logic [5:0] hw, input logic clr);
    A2 = a2; DIn = din; WE = we; PC = pc; BD = bd; ExcCode = ec; HWInt = hw; EXLClr = clr;
    #1;
  endtask

  task automatic peek(input logic [4:0] a);
    A1 = a;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    peek(5'd12);
    total_cnt++; if (Req !== 1'b0) $display("FAIL reset_req: got %0b want 0", Req); else pass_cnt++;
    total_cnt++; if (EPCOut !== 32'd0) $display("FAIL reset_epc: got %h want 0", EPCOut); else pass_cnt++;
    total_cnt++; if (DOut !== 32'd0) $display("FAIL reset_sr: got %h want 0", DOut); else pass_cnt++;
    peek(5'd15);
    total_cnt++; if (DOut !== PRID) $display("FAIL reset_prid: got %h want %h", DOut, PRID); else pass_cnt++;
    peek(5'd13);
    total_cnt++; if (DOut !== 32'd0) $display("FAIL reset_cause: got %h want 0", DOut); else pass_cnt++;
    rst_n = 1'b1;
    clock_step();
  endtask

  task automatic test_interrupt();
    set_inputs(5'd12, 32'h0000_FC01, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    clock_step();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h3010, 1'b0, 5'd0, 6'b000100, 1'b0);
    total_cnt++; if (Req !== 1'b1) $display("FAIL int_req: got %0b want 1", Req); else pass_cnt++;
    clock_step();
    peek(5'd12);
    total_cnt++; if (DOut !== 32'h0000_FC03) $display("FAIL int_sr: got %h want 0000fc03", DOut); else pass_cnt++;
    peek(5'd13);
    total_cnt++; if (DOut !== 32'h0000_1000) $display("FAIL int_cause: got %h want 00001000", DOut); else pass_cnt++;
    total_cnt++; if (EPCOut !== 32'h3010) $display("FAIL int_epc: got %h want 00003010", EPCOut); else pass_cnt++;
  endtask

  task automatic test_exception_bd();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    clock_step();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h3024, 1'b1, 5'd10, 6'd0, 1'b0);
    total_cnt++; if (Req !== 1'b1) $display("FAIL exc_req: got %0b want 1", Req); else pass_cnt++;
    clock_step();
    peek(5'd13);
    total_cnt++; if (DOut !== 32'h8000_0028) $display("FAIL exc_cause: got %h want 80000028", DOut); else pass_cnt++;
    total_cnt++; if (EPCOut !== 32'h3020) $display("FAIL exc_epc: got %h want 00003020", EPCOut); else pass_cnt++;
  endtask

  task automatic test_nested();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h3100, 1'b0, 5'd4, 6'b000100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (Req !== 1'b0) $display("FAIL nest_block%0d: got %0b want 0", i, Req); else pass_cnt++;
      clock_step();
    end
    EXLClr = 1'b1;
    #1;
    total_cnt++; if (Req !== 1'b0) $display("FAIL nest_clrcyc: got %0b want 0", Req); else pass_cnt++;
    clock_step();
    EXLClr = 1'b0;
    peek(5'd12);
    total_cnt++; if (DOut[1] !== 1'b0) $display("FAIL nest_exl: got %0b want 0", DOut[1]); else pass_cnt++;
    total_cnt++; if (Req !== 1'b1) $display("FAIL nest_rereq: got %0b want 1", Req); else pass_cnt++;
    clock_step();
    peek(5'd13);
    total_cnt++; if (DOut !== m_dout(5'd13)) $display("FAIL nest_cause: got %h want %h", DOut, m_dout(5'd13)); else pass_cnt++;
  endtask

  task automatic test_mtc0_vs_req();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    clock_step();
    set_inputs(5'd14, 32'h4000, 1'b1, 32'h5008, 1'b0, 5'd8, 6'd0, 1'b0);
    total_cnt++; if (Req !== 1'b1) $display("FAIL wrreq_req: got %0b want 1", Req); else pass_cnt++;
    clock_step();
    total_cnt++; if (EPCOut !== 32'h5008) $display("FAIL wrreq_epc: got %h want 00005008", EPCOut); else pass_cnt++;
    set_inputs(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    clock_step();
    set_inputs(5'd14, 32'h4000, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    clock_step();
    total_cnt++; if (EPCOut !== 32'h4000) $display("FAIL wr_epc: got %h want 00004000", EPCOut); else pass_cnt++;
  endtask

  task automatic test_priority_reset();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h6000, 1'b0, 5'd12, 6'b000001, 1'b0);
    total_cnt++; if (Req !== 1'b1) $display("FAIL prio_req: got %0b want 1", Req); else pass_cnt++;
    clock_step();
    peek(5'd13);
    total_cnt++; if (DOut[6:2] !== 5'd0) $display("FAIL prio_exccode: got %0d want 0", DOut[6:2]); else pass_cnt++;
    set_inputs(5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    peek(5'd12);
    total_cnt++; if (DOut !== 32'd0) $display("FAIL arst_sr: got %h want 0", DOut); else pass_cnt++;
    total_cnt++; if (EPCOut !== 32'd0) $display("FAIL arst_epc: got %h want 0", EPCOut); else pass_cnt++;
    total_cnt++; if (Req !== 1'b0) $display("FAIL arst_req: got %0b want 0", Req); else pass_cnt++;
    peek(5'd13);
    total_cnt++; if (DOut !== 32'd0) $display("FAIL arst_cause: got %h want 0", DOut); else pass_cnt++;
    rst_n = 1'b1;
    clock_step();
  endtask

  task automatic test_epc_wrap();
    set_inputs(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 6'd0, 1'b0);
    clock_step();
    total_cnt++; if (EPCOut !== 32'hFFFF_FFFC) $display("FAIL wrap_epc: got %h want fffffffc", EPCOut); else pass_cnt++;
    peek(5'd13);
    total_cnt++; if (DOut !== 32'h8000_0010) $display("FAIL wrap_cause: got %h want 80000010", DOut); else pass_cnt++;
  endtask

  task automatic test_mtc0_exlclr();
    set_inputs(5'd12, 32'hFFFF_8403, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    clock_step();
    peek(5'd12);
    total_cnt++; if (DOut !== 32'h0000_8401) $display("FAIL wrclr_sr: got %h want 00008401", DOut); else pass_cnt++;
    set_inputs(5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    clock_step();
    set_inputs(5'd15, 32'h0, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    clock_step();
    peek(5'd13);
    total_cnt++; if (DOut !== 32'h8000_0010) $display("FAIL ro_cause: got %h want 80000010", DOut); else pass_cnt++;
    peek(5'd15);
    total_cnt++; if (DOut !== PRID) $display("FAIL ro_prid: got %h want %h", DOut, PRID); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [4:0] ec;
    for (int i = 0; i < 400; i++) begin
      ec = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      set_inputs(5'($urandom_range(11, 16)), $urandom, ($urandom_range(0, 2) == 0),
                 $urandom, 1'($urandom), ec,
                 ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                 ($urandom_range(0, 2) == 0));
      peek(5'($urandom_range(10, 16)));
      total_cnt++; if (Req !== m_req()) $display("FAIL rnd_req%0d: got %0b want %0b", i, Req, m_req()); else pass_cnt++;
      total_cnt++; if (EPCOut !== m_epc) $display("FAIL rnd_epc%0d: got %h want %h", i, EPCOut, m_epc); else pass_cnt++;
      total_cnt++; if (DOut !== m_dout(A1)) $display("FAIL rnd_dout%0d: a1=%0d got %h want %h", i, A1, DOut, m_dout(A1)); else pass_cnt++;
      clock_step();
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_nested();
    test_mtc0_vs_req();
    test_priority_reset();
    test_epc_wrap();
    test_mtc0_exlclr();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
